// File: rtl/pin_pkg.sv
// Shared key codes and FSM state encoding for the keypad PIN entry path.
package pin_pkg;
   localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
   localparam logic [3:0] KEY_CLEAR     = 4'hE;
   localparam logic [3:0] KEY_ENTER     = 4'hF;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      REPORT  = 2'd1,
      LOCKOUT = 2'd2
   } state_t;
endpackage

// File: rtl/pin_lockout_timer.sv
// Load/expire down-counter that holds o_active for exactly LOCK_CYCLES cycles after a load.
module pin_lockout_timer #(
   parameter int LOCK_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_active,
   output logic o_done
);
   localparam int            CW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(LOCK_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_cnt    <= LOAD_VAL;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt == '0)
            r_active <= 1'b0;
         else
            r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_active = r_active;
   assign o_done   = r_active && (r_cnt == '0);
endmodule

// File: rtl/pin_entry_fsm.sv
// Keypad PIN collector: buffers digits, checks on enter, drives the start/valid
// handshake for the authorization FSM and enforces lockout after repeated failures.
module pin_entry_fsm #(
   parameter int PIN_LEN     = 4,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 1000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           key_valid,
   input  logic [3:0]                     key_code,
   input  logic [4*PIN_LEN-1:0]           pin_code,
   output logic                           key_ready,
   output logic                           auth_start,
   output logic                           auth_valid,
   output logic                           locked,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
   output logic [$clog2(PIN_LEN+1)-1:0]   digit_count
);
   import pin_pkg::*;

   localparam int BW = 4 * PIN_LEN;
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int DW = $clog2(PIN_LEN + 1);

   state_t        r_state;
   logic [BW-1:0] r_buf;
   logic [DW-1:0] r_dcnt;
   logic          r_ovf;
   logic [FW-1:0] r_fail;
   logic [1:0]    r_rep_cnt;
   logic          r_auth_start;
   logic          r_auth_valid;

   logic w_match;
   logic w_lock_load;
   logic w_lock_active;
   logic w_lock_done;

   function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] b, input logic [3:0] k);
      logic [BW-1:0] t;
      t      = b << 4;
      t[3:0] = k;
      return t;
   endfunction

   assign w_match = (r_dcnt == DW'(PIN_LEN)) && !r_ovf && (r_buf == pin_code);

   // Lockout begins on the last report cycle so locked rises exactly as REPORT ends.
   assign w_lock_load = (r_state == REPORT) && (r_rep_cnt == 2'd2) &&
                        (r_fail == FW'(MAX_FAILS));

   pin_lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_lock_load),
      .o_active (w_lock_active),
      .o_done   (w_lock_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= COLLECT;
         r_buf        <= '0;
         r_dcnt       <= '0;
         r_ovf        <= 1'b0;
         r_fail       <= '0;
         r_rep_cnt    <= '0;
         r_auth_start <= 1'b0;
         r_auth_valid <= 1'b0;
      end else begin
         r_auth_start <= 1'b0;
         case (r_state)
            COLLECT: begin
               if (key_valid) begin
                  if (key_code <= KEY_MAX_DIGIT) begin
                     if (r_dcnt != DW'(PIN_LEN)) begin
                        r_buf  <= shift_in(r_buf, key_code);
                        r_dcnt <= r_dcnt + DW'(1);
                     end else begin
                        r_ovf <= 1'b1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     r_buf  <= '0;
                     r_dcnt <= '0;
                     r_ovf  <= 1'b0;
                  end else if (key_code == KEY_ENTER) begin
                     r_buf        <= '0;
                     r_dcnt       <= '0;
                     r_ovf        <= 1'b0;
                     r_state      <= REPORT;
                     r_rep_cnt    <= '0;
                     r_auth_start <= 1'b1;
                     r_auth_valid <= w_match;
                     if (w_match)
                        r_fail <= '0;
                     else if (r_fail != FW'(MAX_FAILS))
                        r_fail <= r_fail + FW'(1);
                  end
               end
            end
            REPORT: begin
               if (r_rep_cnt == 2'd2) begin
                  r_auth_valid <= 1'b0;
                  r_state      <= (r_fail == FW'(MAX_FAILS)) ? LOCKOUT : COLLECT;
               end else begin
                  r_rep_cnt <= r_rep_cnt + 2'd1;
               end
            end
            LOCKOUT: begin
               if (w_lock_done) begin
                  r_fail  <= '0;
                  r_state <= COLLECT;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

   assign key_ready   = (r_state == COLLECT);
   assign locked      = (r_state == LOCKOUT) && w_lock_active;
   assign auth_start  = r_auth_start;
   assign auth_valid  = r_auth_valid;
   assign fail_count  = r_fail;
   assign digit_count = r_dcnt;
endmodule

// File: doc/pin_entry_fsm.md
# pin_entry_fsm

Keypad front-end for the access path: collects decimal digits, compares the entered sequence against a configured PIN on an enter key, and drives the start/valid pair consumed by the authorization FSM. Sequences the start pulse and valid level to match that FSM's IDLE→INPUT→VERIFY progression. Enforces a timed lockout after repeated failures.

## Interface
- PIN_LEN, 4, number of digits in a PIN (1..8)
- MAX_FAILS, 3, consecutive failures that trigger lockout (≥1)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥1)

- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- key_valid  input  1  key_code valid this cycle
- key_code  input  4  0x0-0x9 digit, 0xE clear, 0xF enter, 0xA-0xD ignored
- pin_code  input  4*PIN_LEN  configured PIN; digit 0 (first entered) in the MS nibble; quasi-static
- key_ready  output  1  high when keys are accepted (state COLLECT)
- auth_start  output  1  one-cycle start pulse to authorization FSM
- auth_valid  output  1  PIN-match result, held through the report window
- locked  output  1  high during LOCKOUT
- fail_count  output  $clog2(MAX_FAILS+1)  consecutive failures
- digit_count  output  $clog2(PIN_LEN+1)  digits held in buffer, saturates at PIN_LEN

## Operation
- Reset: state COLLECT; digit buffer, digit_count, overflow flag, fail_count, lock counter = 0; auth_start = auth_valid = locked = 0; key_ready = 1.
- Key accepted when key_valid && key_ready at a rising edge; otherwise ignored, no side effects.
- COLLECT:
  - Digit, digit_count < PIN_LEN: shift into buffer, digit_count+1.
  - Digit, digit_count == PIN_LEN: buffer unchanged, set overflow flag.
  - Clear: buffer, digit_count, overflow = 0; fail_count unchanged.
  - Enter: match = (digit_count == PIN_LEN) && !overflow && (buffer == pin_code). Go to REPORT. Clear buffer, digit_count, and overflow.
  - 0xA-0xD: ignored.
- REPORT (exactly 3 cycles): auth_start = 1 in first cycle only; auth_valid = match for all 3 cycles.
  - Match: fail_count ← 0 at REPORT entry.
  - Mismatch: fail_count +1 at REPORT entry, saturating at MAX_FAILS.
  - Exit: LOCKOUT if fail_count == MAX_FAILS, else COLLECT.
- LOCKOUT: locked = 1, key_ready = 0. Lock counter counts LOCK_CYCLES cycles. On expiry: fail_count ← 0, lock counter ← 0, go to COLLECT.
- pin_code is sampled only on the enter cycle. Changes at other times have no effect.

## Timing
- Enter accepted at edge ending cycle T → auth_start high in T+1 only; auth_valid valid T+1..T+3; key_ready low T+1..T+3.
- Downstream FSM: samples start at end of T+1, is in INPUT during T+2, samples valid at end of T+3. auth_valid must be stable throughout T+1..T+3.
- COLLECT re-entered at T+4, where key_ready = 1, unless lockout applies.
- Lockout: locked high from T+4 for exactly LOCK_CYCLES cycles. key_ready rises in the cycle after locked falls.
- All outputs are registered or decoded from registered state only; no combinational input→output path.
- Reset mid-REPORT or mid-LOCKOUT: immediate return to reset values. A pulse in progress is truncated; fail_count is cleared.
- Back-to-back key_valid every cycle is legal in COLLECT. A key in the enter cycle's successor is dropped because key_ready is low.

## Structure
- Shared package pin_pkg: key code constants (KEY_CLEAR = 4'hE, KEY_ENTER = 4'hF), state enum {COLLECT, REPORT, LOCKOUT} on 2 bits.
- Sub-module pin_lockout_timer: load/expire down-counter, parameter LOCK_CYCLES, outputs active and done.
- Top level: FSM, digit buffer, comparator, fail counter, report-window counter (2 bits).

## Test plan
- pin_code = 0x1234; keys 1,2,3,4,F → auth_start one cycle at T+1, auth_valid = 1 for T+1..T+3, fail_count stays 0, key_ready back at T+4.
- Keys 1,2,3,5,F → auth_valid = 0 for 3 cycles, fail_count = 1; keys 1,2,F (short) → fail_count = 2; keys 1,2,3,4,5,F (overflow) → fail, fail_count = 3.
- With MAX_FAILS = 3, LOCK_CYCLES = 16, three failures → locked high for exactly 16 cycles; keys during lockout ignored; then fail_count = 0, key_ready = 1.
- Keys 9,9,E,1,2,3,4,F → match. Keys 0xA-0xD interleaved with a correct PIN → match, digit_count unaffected.
- Two failures then a correct PIN → fail_count returns to 0. Reset asserted in T+2 of a REPORT → all outputs at reset values the same cycle, auth_valid low.
